multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory wait timeout and illegal-opcode pulse.
// Optional BNE support enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       mem_err,
  output logic       illegal_op
);

  localparam int CW = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, ill_q, ill_d;
  logic          wait_st, tmo;
  logic          op_lw, op_sw, op_r, op_imm;
  logic          op_beq, op_bne, op_j, op_nop;

  assign op_lw  = Opcode == 6'b100011;
  assign op_sw  = Opcode == 6'b101011;
  assign op_r   = Opcode == 6'b000000;
  assign op_imm = Opcode inside {6'b001000, 6'b001100,
                                 6'b001101, 6'b001011};
  assign op_beq = Opcode == 6'b000100;
  assign op_j   = Opcode == 6'b000010;
  assign op_nop = Opcode == 6'b111111;
`ifdef MULTICYCLE_BNE_EN
  assign op_bne = Opcode == 6'b000101;
`else
  assign op_bne = 1'b0;
`endif

  assign wait_st = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign tmo = wait_st && !mem_ready &&
               (cnt_q == CW'(MEM_TIMEOUT));

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    state_d     = state_q;
    ill_d       = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        unique case (1'b1)
          op_lw, op_sw:   state_d = S_MEMADR;
          op_r:           state_d = S_EXEC;
          op_imm:         state_d = S_IEXEC;
          op_beq, op_bne: state_d = S_BRANCH;
          op_j:           state_d = S_JUMP;
          op_nop:         state_d = S_FETCH;
          default: begin
            state_d = S_FETCH;
            ill_d   = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op_lw)      state_d = S_MEMRD;
        else if (op_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        state_d = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchNe    = op_bne;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // a stalled access gives up and refetches
    if (tmo) state_d = S_FETCH;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (tmo || state_d != state_q) cnt_d = '0;
    else if (wait_st && !mem_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= tmo;
      ill_q   <= ill_d;
    end
  end

  assign state      = state_q;
  assign mem_err    = err_q;
  assign illegal_op = ill_q;

endmodule
